// File: rtl/title_logo_if.sv
// Pixel/ROM path between the VGA scan, the logo ROM and the color mapper.
interface title_logo_if;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [11:0] rom_color;
  logic [17:0] read_address;
  logic        logo_on;
  logic [11:0] logo_color;

  modport slave  (input DrawX, DrawY, rom_color, output read_address, logo_on, logo_color);
  modport master (output DrawX, DrawY, rom_color, input read_address, logo_on, logo_color);
endinterface

// File: rtl/title_logo_ctrl.sv
// Title logo sequencer: per-frame drop/hold/exit motion plus a 2-stage
// scan-to-ROM pipeline producing logo visibility and color.
module title_logo_ctrl #(
  parameter int          LOGO_W = 352,
  parameter int          LOGO_H = 176,
  parameter int          LOGO_X = 144,
  parameter int          HOLD_Y = 64,
  parameter int          STEP   = 4,
  parameter logic [11:0] TRANSP = 12'h808
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         frame_start,
  input  logic         title_en,
  input  logic         start_key,
  title_logo_if.slave  pix,
  output logic [1:0]   state,
  output logic         done
);

  typedef enum logic [1:0] {IDLE = 2'd0, DROP = 2'd1, HOLD = 2'd2, EXIT = 2'd3} state_t;

  localparam logic signed [10:0] Y_OFF  = 11'(-LOGO_H);
  localparam logic signed [10:0] Y_HOLD = 11'(HOLD_Y);
  localparam logic signed [10:0] Y_STEP = 11'(STEP);
  localparam logic signed [11:0] X_LO   = 12'(LOGO_X);
  localparam logic signed [11:0] X_HI   = 12'(LOGO_X + LOGO_W);
  localparam logic signed [11:0] H12    = 12'(LOGO_H);

  state_t             st;
  logic signed [10:0] logo_y;
  logic signed [10:0] y_up, y_dn;

  assign state = st;
  assign y_up  = logo_y + Y_STEP;
  assign y_dn  = logo_y - Y_STEP;

  // logo_y only moves on frame_start so it is frozen across the visible frame
  always_ff @(posedge Clk) begin
    if (Reset) begin
      st     <= IDLE;
      logo_y <= Y_OFF;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!title_en) begin
        st     <= IDLE;
        logo_y <= Y_OFF;
      end else begin
        case (st)
          IDLE: begin
            logo_y <= Y_OFF;
            st     <= DROP;
          end
          DROP: if (frame_start) begin
            if (y_up >= Y_HOLD) begin
              logo_y <= Y_HOLD;
              st     <= HOLD;
            end else begin
              logo_y <= y_up;
            end
          end
          HOLD: if (start_key) st <= EXIT;
          EXIT: if (frame_start) begin
            if (y_dn <= Y_OFF) begin
              logo_y <= Y_OFF;
              done   <= 1'b1;
              st     <= IDLE;
            end else begin
              logo_y <= y_dn;
            end
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

  logic signed [11:0] dx, dy, ly, ly_end, row, col;
  logic [17:0]        r18, c18, addr_c;
  logic               in_win, in_win_d, opaque;

  assign dx     = $signed({2'b00, pix.DrawX});
  assign dy     = $signed({2'b00, pix.DrawY});
  assign ly     = {logo_y[10], logo_y};
  assign ly_end = ly + H12;
  assign in_win = (dx >= X_LO) && (dx < X_HI) && (dy >= ly) && (dy < ly_end) && (st != IDLE);

  assign row    = dy - ly;
  assign col    = dx - X_LO;
  assign r18    = {{6{row[11]}}, row};
  assign c18    = {{6{col[11]}}, col};
  // row * 352 as (row<<8) + (row<<6) + (row<<5)
  assign addr_c = (r18 << 8) + (r18 << 6) + (r18 << 5) + c18;

  assign opaque = in_win_d && (pix.rom_color != TRANSP);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      in_win_d         <= 1'b0;
      pix.read_address <= '0;
      pix.logo_on      <= 1'b0;
      pix.logo_color   <= '0;
    end else begin
      in_win_d         <= in_win;
      pix.read_address <= in_win ? addr_c : '0;
      pix.logo_on      <= opaque;
      pix.logo_color   <= opaque ? pix.rom_color : 12'h000;
    end
  end

endmodule

// File: tb/tb_title_logo_ctrl.sv
// Bench for title_logo_ctrl: directed pins of the spec sequence plus random
// traffic, all checked every cycle against an integer model of the logo.
module tb_title_logo_ctrl;
  logic Clk = 1'b0;
  logic Reset, frame_start, title_en, start_key;
  logic [1:0] state;
  logic done;
  title_logo_if pix ();

  int n_cmp = 0, n_bad = 0;
  bit chk_en = 1'b0;
  bit rom_mode = 1'b0;
  logic [11:0] rom_fix = 12'h0AE;

  function automatic logic [11:0] rom_fn(logic [17:0] a, bit mode, logic [11:0] fix);
    if (mode) return fix;
    return (a[2:0] == 3'd5) ? 12'h808 : (a[11:0] ^ 12'h3C5);
  endfunction

  assign pix.rom_color = rom_fn(pix.read_address, rom_mode, rom_fix);

  title_logo_ctrl dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .title_en(title_en),
    .start_key(start_key), .pix(pix.slave), .state(state), .done(done)
  );

  always #5 Clk = ~Clk;

  task automatic check(string nm, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: integer position and phase, window from geometry.
  int m_state = 0, m_y = -176, m_done = 0;
  int e_win1 = 0, e_addr1 = 0, e_on = 0, e_col = 0;

  always @(posedge Clk) begin
    int x, y, w;
    logic [11:0] rc;
    x  = int'(pix.DrawX);
    y  = int'(pix.DrawY);
    rc = rom_fn(18'(e_addr1), rom_mode, rom_fix);
    w  = (x >= 144 && x < 144 + 352 && y >= m_y && y < m_y + 176 && m_state != 0) ? 1 : 0;
    if (Reset) begin
      e_win1 <= 0; e_addr1 <= 0; e_on <= 0; e_col <= 0;
      m_state <= 0; m_y <= -176; m_done <= 0;
    end else begin
      e_win1  <= w;
      e_addr1 <= w ? (((y - m_y) * 352 + (x - 144)) & 32'h3FFFF) : 0;
      e_on    <= (e_win1 != 0 && rc != 12'h808) ? 1 : 0;
      e_col   <= (e_win1 != 0 && rc != 12'h808) ? int'(rc) : 0;
      m_done  <= 0;
      if (!title_en) begin
        m_state <= 0; m_y <= -176;
      end else if (m_state == 0) begin
        m_state <= 1; m_y <= -176;
      end else if (m_state == 1 && frame_start) begin
        m_y <= (m_y + 4 > 64) ? 64 : m_y + 4;
        if (m_y + 4 >= 64) m_state <= 2;
      end else if (m_state == 2 && start_key) begin
        m_state <= 3;
      end else if (m_state == 3 && frame_start) begin
        if (m_y - 4 <= -176) begin
          m_y <= -176; m_done <= 1; m_state <= 0;
        end else m_y <= m_y - 4;
      end
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      check("state", int'(state), m_state);
      check("done", int'(done), m_done);
      check("logo_y", int'($signed(dut.logo_y)), m_y);
      check("read_address", int'(pix.read_address), e_addr1);
      check("logo_on", int'(pix.logo_on), e_on);
      check("logo_color", int'(pix.logo_color), e_col);
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
  endtask

  task automatic set_pix(int x, int y);
    pix.DrawX = 10'(x);
    pix.DrawY = 10'(y);
  endtask

  initial begin
    Reset = 1'b1; frame_start = 1'b0; title_en = 1'b0; start_key = 1'b0;
    set_pix(0, 0);
    tick();
    chk_en = 1'b1;
    tick();
    check("rst_state", int'(state), 0);
    check("rst_logo_y", int'($signed(dut.logo_y)), -176);
    check("rst_addr", int'(pix.read_address), 0);
    check("rst_on", int'(pix.logo_on), 0);
    check("rst_done", int'(done), 0);
    Reset = 1'b0;

    // drop-in: 60 frames from -176 to 64
    title_en = 1'b1;
    tick();
    check("enter_drop", int'(state), 1);
    for (int i = 0; i < 59; i++) pulse();
    check("drop59_state", int'(state), 1);
    check("drop59_y", int'($signed(dut.logo_y)), 60);
    pulse();
    check("drop60_state", int'(state), 2);
    check("drop60_y", int'($signed(dut.logo_y)), 64);

    // addresses while held
    set_pix(144, 64);  tick(); check("addr_origin", int'(pix.read_address), 0);
    set_pix(495, 239); tick(); check("addr_last", int'(pix.read_address), 61951);
    set_pix(496, 239); tick(); check("addr_right_out", int'(pix.read_address), 0);

    // two-cycle latency of logo_on and transparency
    rom_mode = 1'b1; rom_fix = 12'h0AE;
    set_pix(0, 0); tick(); tick();
    set_pix(144, 64); tick();
    check("on_lat1", int'(pix.logo_on), 0);
    tick();
    check("on_lat2", int'(pix.logo_on), 1);
    check("color_0ae", int'(pix.logo_color), 12'h0AE);
    rom_fix = 12'h808; tick();
    check("transp_on", int'(pix.logo_on), 0);
    check("transp_color", int'(pix.logo_color), 0);
    rom_fix = 12'h0AE; tick();
    check("opaque_on", int'(pix.logo_on), 1);

    // exit with start_key coinciding with frame_start
    start_key = 1'b1; frame_start = 1'b1; tick();
    start_key = 1'b0; frame_start = 1'b0;
    check("exit_state", int'(state), 3);
    check("exit_y", int'($signed(dut.logo_y)), 64);
    for (int i = 0; i < 59; i++) pulse();
    check("exit59_done", int'(done), 0);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    check("exit_done", int'(done), 1);
    check("exit_idle", int'(state), 0);
    check("exit_y_end", int'($signed(dut.logo_y)), -176);
    tick();
    check("done_one_cycle", int'(done), 0);

    // partially visible logo at logo_y = -100
    for (int i = 0; i < 19; i++) pulse();
    check("part_y", int'($signed(dut.logo_y)), -100);
    for (int y = 0; y < 80; y++) begin
      set_pix(150, y);
      tick();
      if (y == 0) check("part_addr_row0", int'(pix.read_address), 35206);
      tick();
      check("part_on", int'(pix.logo_on), (y < 76) ? 1 : 0);
    end

    // title_en drop during DROP
    title_en = 1'b0; tick();
    check("abort_state", int'(state), 0);
    check("abort_y", int'($signed(dut.logo_y)), -176);
    check("abort_done", int'(done), 0);
    title_en = 1'b1; tick();
    for (int i = 0; i < 60; i++) pulse();
    start_key = 1'b1; tick(); start_key = 1'b0;
    for (int i = 0; i < 3; i++) pulse();
    check("pre_reset_exit", int'(state), 3);
    set_pix(200, 100);
    Reset = 1'b1; tick(); Reset = 1'b0;
    check("rst_exit_state", int'(state), 0);
    check("rst_exit_y", int'($signed(dut.logo_y)), -176);
    check("rst_exit_done", int'(done), 0);
    check("rst_exit_addr", int'(pix.read_address), 0);
    check("rst_exit_on", int'(pix.logo_on), 0);

    // random traffic
    rom_mode = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      Reset       = ($urandom_range(299) == 0);
      title_en    = ($urandom_range(399) != 0);
      frame_start = ($urandom_range(3) == 0);
      start_key   = ($urandom_range(19) == 0);
      if ($urandom_range(1) == 0)
        set_pix($urandom_range(639), $urandom_range(479));
      else
        set_pix($urandom_range(140, 500), $urandom_range(0, 245));
      tick();
    end
    Reset = 1'b0; frame_start = 1'b0; start_key = 1'b0;
    tick();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
